// File: rtl/kab_int_receiver.sv
`default_nettype none
// ============================================================================
// kab_int_receiver : external interrupt handshake receiver (IO subsystem side
//                    to pipeline). Optional WAIT_DROP timeout: KAB_INT_TIMEOUT_EN
// Revision 1.0 - initial release
// ============================================================================
module kab_int_receiver #(
    parameter int          ID_W      = 1,
    parameter logic [31:0] VEC_BASE  = 32'h0000_0100,
    parameter int          VEC_SHIFT = 4,
    parameter int          TIMEOUT   = 255
) (
    input  logic            Sys_Clock,
    input  logic            Sys_Reset,
    input  logic            EIC_IntReq,
    input  logic [ID_W-1:0] EIC_IntId,
    output logic            EIC_IntAck,
    input  logic            Int_Enable,
    input  logic            Int_Take,
    output logic            Int_Pending,
    output logic [31:0]     Int_Vector,
    input  logic            Int_ErrClr,
    output logic            Int_Error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PEND      = 2'd1,
        ACK       = 2'd2,
        WAIT_DROP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              capture;
    logic              qualify;
    logic              timeout_hit;
    logic [ID_W-1:0]   id_reg;

`ifdef KAB_INT_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] cnt;
    logic             need_drop;
    logic             error_q;

    // After a forced exit the request is still high; it must drop first.
    assign qualify     = EIC_IntReq && Int_Enable && !need_drop;
    assign timeout_hit = (state == WAIT_DROP) && EIC_IntReq &&
                         (cnt == CNT_W'(TIMEOUT - 1));
    assign Int_Error   = error_q;

    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            cnt       <= '0;
            need_drop <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            if (state != WAIT_DROP && state_nxt == WAIT_DROP)
                cnt <= '0;
            else if (state == WAIT_DROP)
                cnt <= cnt + 1'b1;

            if (timeout_hit)
                need_drop <= 1'b1;
            else if (!EIC_IntReq)
                need_drop <= 1'b0;

            if (timeout_hit)
                error_q <= 1'b1;
            else if (Int_ErrClr)
                error_q <= 1'b0;
        end
    end
`else
    logic unused_cfg;

    assign qualify     = EIC_IntReq && Int_Enable;
    assign timeout_hit = 1'b0;
    assign Int_Error   = 1'b0;
    assign unused_cfg  = Int_ErrClr ^ (TIMEOUT != 0);
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (qualify) begin
                    capture   = 1'b1;
                    state_nxt = PEND;
                end
            end
            PEND: begin
                // Take wins over withdrawal or masking in the same cycle.
                if (Int_Take)
                    state_nxt = ACK;
                else if (!EIC_IntReq || !Int_Enable)
                    state_nxt = IDLE;
            end
            ACK:       state_nxt = WAIT_DROP;
            WAIT_DROP: begin
                if (!EIC_IntReq || timeout_hit)
                    state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Sys_Clock) begin
        if (Sys_Reset) begin
            state       <= IDLE;
            EIC_IntAck  <= 1'b0;
            Int_Pending <= 1'b0;
            id_reg      <= '0;
        end else begin
            state       <= state_nxt;
            EIC_IntAck  <= (state_nxt == ACK);
            Int_Pending <= (state_nxt == PEND);
            if (capture)
                id_reg <= EIC_IntId;
        end
    end

    // Derived from the held ID, so it keeps its value outside PEND.
    assign Int_Vector = VEC_BASE + (32'(id_reg) << VEC_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_kab_int_receiver.sv
`default_nettype none
// ============================================================================
// tb_kab_int_receiver : directed table-driven bench for kab_int_receiver
// Revision 1.0 - initial release
// ============================================================================
module tb_kab_int_receiver;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [1:0]  id;
    logic        en;
    logic        take;
    logic        clr;
    logic        ack,  ack2;
    logic        pend, pend2;
    logic [31:0] vec,  vec2;
    logic        err,  err2;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    kab_int_receiver #(.ID_W(2), .VEC_BASE(32'h0000_0100), .VEC_SHIFT(4), .TIMEOUT(8)) dut (
        .Sys_Clock(clk), .Sys_Reset(rst), .EIC_IntReq(req), .EIC_IntId(id),
        .EIC_IntAck(ack), .Int_Enable(en), .Int_Take(take), .Int_Pending(pend),
        .Int_Vector(vec), .Int_ErrClr(clr), .Int_Error(err)
    );

    // Base near the top of the address space to exercise wrap-around.
    kab_int_receiver #(.ID_W(2), .VEC_BASE(32'hFFFF_FFF8), .VEC_SHIFT(4), .TIMEOUT(8)) dut_wrap (
        .Sys_Clock(clk), .Sys_Reset(rst), .EIC_IntReq(req), .EIC_IntId(id),
        .EIC_IntAck(ack2), .Int_Enable(en), .Int_Take(take), .Int_Pending(pend2),
        .Int_Vector(vec2), .Int_ErrClr(clr), .Int_Error(err2)
    );

    typedef struct {
        logic        req;
        logic [1:0]  id;
        logic        en;
        logic        take;
        logic        clr;
        logic        exp_pend;
        logic        exp_ack;
        logic [31:0] exp_vec;
    } row_t;

    row_t rows[$];

    function automatic void add(input logic r, input logic [1:0] i, input logic e,
                                input logic t, input logic c, input logic p,
                                input logic a, input logic [31:0] v);
        row_t x;
        x.req = r; x.id = i; x.en = e; x.take = t; x.clr = c;
        x.exp_pend = p; x.exp_ack = a; x.exp_vec = v;
        rows.push_back(x);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; id = 2'd0; en = 1'b0; take = 1'b0; clr = 1'b0;
        step();
        step();
        chk("reset pend",  32'(pend), 32'd0);
        chk("reset ack",   32'(ack),  32'd0);
        chk("reset vec",   vec,       32'h0000_0100);
        chk("reset vec2",  vec2,      32'hFFFF_FFF8);
        chk("reset err",   32'(err),  32'd0);
        rst = 1'b0;

        //   req id en tk clr  pend ack vector
        // basic handshake
        add(0, 0, 1, 0, 0,   0, 0, 32'h100);
        add(1, 1, 1, 0, 0,   1, 0, 32'h110);
        add(1, 1, 1, 0, 0,   1, 0, 32'h110);
        add(1, 1, 1, 1, 0,   0, 1, 32'h110);
        add(1, 1, 1, 0, 0,   0, 0, 32'h110);
        add(1, 1, 1, 0, 0,   0, 0, 32'h110);
        add(0, 0, 1, 0, 0,   0, 0, 32'h110);
        // masked request, then enable
        for (int k = 0; k < 10; k++)
            add(1, 2, 0, 0, 0, 0, 0, 32'h110);
        add(1, 2, 1, 0, 0,   1, 0, 32'h120);
        // withdraw without take
        add(0, 2, 1, 0, 0,   0, 0, 32'h120);
        // take in the same cycle the request drops
        add(1, 3, 1, 0, 0,   1, 0, 32'h130);
        add(0, 0, 1, 1, 0,   0, 1, 32'h130);
        add(0, 0, 1, 0, 0,   0, 0, 32'h130);
        add(0, 0, 1, 1, 1,   0, 0, 32'h130);
        add(0, 0, 1, 1, 1,   0, 0, 32'h130);
        // masking in PEND, then take beating mask
        add(1, 1, 1, 0, 0,   1, 0, 32'h110);
        add(1, 1, 0, 0, 0,   0, 0, 32'h110);
        add(1, 1, 0, 0, 0,   0, 0, 32'h110);
        add(1, 2, 1, 0, 0,   1, 0, 32'h120);
        add(1, 2, 0, 1, 0,   0, 1, 32'h120);
        // re-arm: request held after ack gives no second pending
        for (int k = 0; k < 5; k++)
            add(1, 2, 1, 0, 0, 0, 0, 32'h120);
        add(0, 0, 1, 0, 0,   0, 0, 32'h120);
        add(1, 1, 1, 0, 0,   1, 0, 32'h110);
        add(1, 1, 1, 1, 0,   0, 1, 32'h110);

        foreach (rows[i]) begin
            req = rows[i].req; id = rows[i].id; en = rows[i].en;
            take = rows[i].take; clr = rows[i].clr;
            step();
            chk($sformatf("row%0d pend", i), 32'(pend), 32'(rows[i].exp_pend));
            chk($sformatf("row%0d ack",  i), 32'(ack),  32'(rows[i].exp_ack));
            chk($sformatf("row%0d vec",  i), vec,       rows[i].exp_vec);
            chk($sformatf("row%0d vec2", i), vec2,      rows[i].exp_vec + 32'hFFFF_FEF8);
            chk($sformatf("row%0d err",  i), 32'(err),  32'd0);
        end

        // reset during the ack cycle
        rst = 1'b1; take = 1'b0;
        step();
        chk("rstack pend", 32'(pend), 32'd0);
        chk("rstack ack",  32'(ack),  32'd0);
        chk("rstack vec",  vec,       32'h0000_0100);
        chk("rstack vec2", vec2,      32'hFFFF_FFF8);
        rst = 1'b0; req = 1'b0;
        step();
        chk("post rst pend", 32'(pend), 32'd0);

`ifdef KAB_INT_TIMEOUT_EN
        req = 1'b1; id = 2'd1; en = 1'b1; take = 1'b0; clr = 1'b0;
        step();
        chk("to pend", 32'(pend), 32'd1);
        take = 1'b1;
        step();
        chk("to ack", 32'(ack), 32'd1);
        take = 1'b0;
        step();
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("to err k%0d", k), 32'(err), (k == 8) ? 32'd1 : 32'd0);
        end
        chk("to exit pend", 32'(pend), 32'd0);
        step();
        chk("to held no pend", 32'(pend), 32'd0);
        req = 1'b0;
        step();
        req = 1'b1;
        step();
        chk("to requal pend", 32'(pend), 32'd1);
        chk("to err sticky",  32'(err),  32'd1);
        req = 1'b0; clr = 1'b1;
        step();
        chk("to errclr", 32'(err), 32'd0);
        clr = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/kab_int_receiver.md
# kab_int_receiver

Processor-side receiver for the external interrupt handshake driven by the IO subsystem (`EIC_IntReq` / `EIC_IntId` / `EIC_IntAck`). It sits between the IO subsystem and the pipeline's exception logic. It qualifies requests against the processor interrupt-enable, latches the interrupt ID, and presents a pending flag plus handler vector to the pipeline. When the pipeline takes the interrupt, it returns a one-cycle acknowledge to the controller, then waits for the request to drop before re-arming.

## Interface
Parameters:
- `ID_W`, default 1: width of `EIC_IntId`.
- `VEC_BASE`, default 32'h0000_0100: handler vector base address.
- `VEC_SHIFT`, default 4: left shift applied to the ID when forming the vector.
- `TIMEOUT`, default 255: maximum cycles in WAIT_DROP. Used only with `KAB_INT_TIMEOUT_EN`.

Ports:
- `Sys_Clock` in 1: system clock. Single clock domain.
- `Sys_Reset` in 1: reset, synchronous and active-high.
- `EIC_IntReq` in 1: interrupt request from the controller. Level, held until acknowledged.
- `EIC_IntId` in `ID_W`: interrupt ID. Valid while `EIC_IntReq`=1.
- `EIC_IntAck` out 1: acknowledge to the controller. Registered, one-cycle pulse.
- `Int_Enable` in 1: processor interrupt enable. 0 means interrupts are masked (e.g. supervisor mode).
- `Int_Take` in 1: pipeline accepts the pending interrupt at an instruction boundary.
- `Int_Pending` out 1: interrupt pending toward the pipeline.
- `Int_Vector` out 32: handler address, computed as `VEC_BASE + (IntIdReg << VEC_SHIFT)`.
- `Int_ErrClr` in 1: clears `Int_Error`.
- `Int_Error` out 1: sticky handshake-timeout flag.

## Operation
- FSM states: IDLE, PEND, ACK, WAIT_DROP.
- **IDLE**
  - If `EIC_IntReq`=1 and `Int_Enable`=1, capture `EIC_IntId` into `IntIdReg` and go to PEND.
  - Otherwise stay in IDLE.
- **PEND**
  - `Int_Pending`=1 and `Int_Vector` is valid.
  - If `Int_Take`=1, go to ACK. Take has priority over withdrawal and masking in the same cycle.
  - Else if `EIC_IntReq`=0 (withdrawn) or `Int_Enable`=0, go to IDLE with no ack.
- **ACK**
  - `EIC_IntAck`=1 for exactly this one cycle, then go to WAIT_DROP.
  - `Int_Pending`=0.
- **WAIT_DROP**
  - Ignore requests.
  - Go to IDLE on the first cycle `EIC_IntReq`=0.
  - The controller deasserts `EIC_IntReq` for at least one cycle after each ack. A new request is recognised only after that drop.
- `Int_Take` is ignored in IDLE, ACK and WAIT_DROP.
- `Int_Vector` is formed from the 32-bit sum, modulo 2^32 (wrap-around).
- `Int_Vector` holds its last value outside PEND.
- `Int_Error` is set only by a timeout and cleared by `Int_ErrClr`. If set and clear occur in the same cycle, set wins.

## Timing
- **Reset values:** state=IDLE, `EIC_IntAck`=0, `Int_Pending`=0, `Int_Vector`=`VEC_BASE`, `IntIdReg`=0, `Int_Error`=0, timeout counter=0.
- **Request to pending:** `EIC_IntReq` is sampled high at edge N, and `Int_Pending`=1 after edge N (1 cycle).
- **Take to ack:** `Int_Take` is sampled at edge M, and `EIC_IntAck`=1 for the cycle after edge M. `Int_Pending` falls at the same edge.
- **Minimum request-to-request spacing:** IDLE → PEND → ACK → WAIT_DROP → IDLE. This takes at least 4 cycles plus the time the controller holds the request after the ack.
- **Reset mid-operation:** all outputs return to reset values at the next edge. An in-flight ack is truncated, and the controller re-sends the request.

## Configuration
- `KAB_INT_TIMEOUT_EN` defined:
  - An 8-bit-or-wider counter clears on entry to WAIT_DROP and increments each cycle while in WAIT_DROP.
  - When it reaches `TIMEOUT` with `EIC_IntReq` still 1: set `Int_Error` and go to IDLE. The request must drop before it can re-qualify, because entry from IDLE requires a fresh high sample after the forced exit.
- `KAB_INT_TIMEOUT_EN` undefined:
  - No counter is built. WAIT_DROP waits indefinitely.
  - `Int_Error` is tied to 0 and `Int_ErrClr` is ignored.

## Test plan
- **Basic handshake:** ID=1, Enable=1, request raised. Expect Pending=1 one cycle later with Vector=32'h0000_0110. Take pulse → Ack high for exactly 1 cycle. Request dropped 2 cycles later → IDLE.
- **Masked request:** Enable=0 with request held high for 10 cycles. Expect Pending=0 and Ack=0 throughout. Raise Enable → Pending=1 the next cycle.
- **Withdraw vs take:** in PEND, drop the request with Take=0 → IDLE, no ack. Repeat with Take=1 and the request dropping in the same cycle → Ack=1.
- **Re-arm rule:** after the ack, hold the request high for 5 cycles. Expect no second Pending until the request drops and rises again.
- **Timeout** (`KAB_INT_TIMEOUT_EN`, `TIMEOUT`=8): hold the request high after the ack. Expect Error=1 after 8 WAIT_DROP cycles and state=IDLE. Drop and re-raise the request → Pending=1. ErrClr → Error=0.
- **Reset in ACK:** assert `Sys_Reset` during the ack cycle. At the next edge expect Ack=0, Pending=0, Vector=32'h0000_0100.
